alu_ctrl_decode: RTL and testbench
==================================

# alu_ctrl_decode

Decode-side producer of the EX-stage ALU control interface in the two-issue RV32I core. Accepts one fetched instruction per cycle over a valid/ready handshake, decodes OP, OP-IMM, LUI and AUIPC into the ALU's 3-bit `alu_op` / `alu_op_chosen` encoding plus operand selects, register indices and immediate, and presents the result through a two-entry skid buffer. One instance per issue lane.

## Interface
- No parameters.
- `clk` in 1 — clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `flush` in 1 — synchronous pipeline flush.
- `in_valid` in 1 — instruction present.
- `in_ready` out 1 — buffer can accept; registered.
- `in_inst` in 32 — raw instruction.
- `in_pc` in 32 — instruction PC.
- `out_valid` out 1 — decoded entry present.
- `out_ready` in 1 — EX accepts entry.
- `out_alu_op` out 3 — funct3-style op: 000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and.
- `out_alu_op_chosen` out 1 — 1 selects sub (op 000) or sra (op 101).
- `out_src1_sel` out 2 — 00 rs1, 01 zero, 10 pc.
- `out_src2_imm` out 1 — 1 selects `out_imm`, 0 selects rs2.
- `out_imm` out 32 — decoded immediate.
- `out_rs1`, `out_rs2`, `out_rd` out 5 each — register indices.
- `out_rd_we` out 1 — writeback enable (0 when rd = x0).
- `out_illegal` out 1 — unsupported encoding.
- `out_pc` out 32 — PC passed through.

## Operation
- Decode is combinational on `in_inst`; results are captured only on a transfer (`in_valid & in_ready`).
- OP (0110011): `alu_op`=funct3; `alu_op_chosen`=inst[30] for funct3 000/101, else 0; `src2_imm`=0; `src1_sel`=00. Illegal if funct7 ∉ {0000000, 0100000}, or if funct7=0100000 with funct3 ∉ {000, 101}.
- OP-IMM (0010011): `src2_imm`=1; `imm`=sign-extended inst[31:20]. For funct3 001/101, `imm`={27'b0, inst[24:20]} and `alu_op_chosen`=inst[30] (101 only). Illegal if slli funct7≠0, or if srli/srai funct7 ∉ {0000000, 0100000}. addi never sets `chosen`.
- LUI: op 000, chosen 0, `src1_sel`=01, `imm`={inst[31:12], 12'b0}. AUIPC: same with `src1_sel`=10.
- Any other opcode is illegal. `rs2` is forced to 0 for non-OP formats.
- Skid buffer holds a main entry and a skid entry, each with a valid bit.
  - Main is empty or draining (`out_ready`): the new entry goes to main.
  - Main is stalled: the new entry goes to skid.
  - When main drains and skid is valid, skid moves to main.
- Order is strictly FIFO. `in_ready` is registered as !skid_valid_next.
- `flush`: both valid bits clear at the next edge; an input transferred in the flush cycle is discarded; `in_ready` returns to 1.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`. Throughput: 1/cycle with `out_ready` high.
- Reset: `out_valid`=0, `in_ready`=1, all other outputs 0; both entries empty.
- Outputs are stable while `out_valid & ~out_ready`.
- `in_ready` deasserts the cycle after the skid entry fills. It reasserts the cycle after skid drains or a flush occurs.
- Reset asserted mid-operation drops all entries asynchronously.

## Configuration
- `DEC_ILLEGAL_TRAP_EN` defined: illegal encodings set `out_illegal`=1 and `out_rd_we`=0; the remaining fields are don't-care.
- Undefined: `out_illegal` is tied 0 and illegal encodings decode as addi x0,x0,0 (op 000, `src2_imm`=1, `imm`=0, `rd_we`=0).

## Test plan
- 0x002081B3 (add x3,x1,x2) → next cycle: `out_valid`=1, op 000, chosen 0, rs1 1, rs2 2, rd 3, `src2_imm` 0, `rd_we` 1.
- 0x407302B3 (sub x5,x6,x7) → op 000, chosen 1. Then 0x40315093 (srai x1,x2,3) → op 101, chosen 1, imm 0x00000003, `src2_imm` 1.
- 0xFFF00093 (addi x1,x0,-1) → imm 0xFFFFFFFF, chosen 0. 0x12345537 (lui x10) → `src1_sel` 01, imm 0x12345000.
- Hold `out_ready`=0 and offer three instructions back-to-back → two are accepted and `in_ready`=0 from the third cycle. Raise `out_ready` → entries leave in order, then the third is accepted.
- Buffer full, assert `flush` with `in_valid`=1 → next cycle `out_valid`=0 and `in_ready`=1; the flushed input never appears.
- 0x0000007F → with macro: `out_illegal`=1, `rd_we`=0; without macro: `out_illegal`=0, op 000, imm 0, `rd_we`=0.

Source files
------------

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: decodes OP, OP-IMM, LUI and AUIPC instructions into the
// EX-stage ALU control fields. A two-entry skid buffer (main + skid) holds
// the decoded results, so in_ready can be a registered signal.
// Optional feature macro: DEC_ILLEGAL_TRAP_EN. When it is defined, illegal
// encodings raise out_illegal. When it is undefined, illegal encodings
// decode as addi x0,x0,0.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload steady until the
// transfer. A consumer may change ready at any time. On the input side,
// ready does not depend on valid. On the output side, every out_* field is
// held stable while out_valid is high and out_ready is low.
module alu_ctrl_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_alu_op,
  output logic        out_alu_op_chosen,
  output logic [1:0]  out_src1_sel,
  output logic        out_src2_imm,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic        out_illegal,
  output logic [31:0] out_pc
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef struct packed {
    logic [2:0]  alu_op;
    logic        chosen;
    logic [1:0]  src1_sel;
    logic        src2_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
    logic [31:0] pc;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal_enc;
  entry_t     dec;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  // Decode the raw instruction into a buffer entry. This logic is
  // combinational; the result is only captured when a transfer occurs.
  always_comb begin
    dec         = '0;
    illegal_enc = 1'b0;
    dec.pc      = in_pc;
    dec.rs1     = in_inst[19:15];
    dec.rd      = in_inst[11:7];
    case (opcode)
      OPC_OP: begin
        dec.alu_op = funct3;
        dec.rs2    = in_inst[24:20];
        if (funct3 == 3'b000 || funct3 == 3'b101) dec.chosen = in_inst[30];
        illegal_enc = !((funct7 == F7_BASE) ||
                        (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_IMM: begin
        dec.alu_op   = funct3;
        dec.src2_imm = 1'b1;
        dec.imm      = {{20{in_inst[31]}}, in_inst[31:20]};
        if (funct3 == 3'b001) begin
          dec.imm     = {27'b0, in_inst[24:20]};
          illegal_enc = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          dec.imm     = {27'b0, in_inst[24:20]};
          dec.chosen  = in_inst[30];
          illegal_enc = !(funct7 == F7_BASE || funct7 == F7_ALT);
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        // U-type has no rs1 field; report x0 instead of immediate bits
        dec.rs1      = 5'd0;
        dec.src1_sel = (opcode == OPC_LUI) ? 2'b01 : 2'b10;
        dec.src2_imm = 1'b1;
        dec.imm      = {in_inst[31:12], 12'b0};
      end
      default: illegal_enc = 1'b1;
    endcase
    dec.rd_we = (dec.rd != 5'd0) && !illegal_enc;
`ifdef DEC_ILLEGAL_TRAP_EN
    dec.illegal = illegal_enc;
`else
    // Without trapping, an illegal instruction becomes a harmless addi x0,x0,0
    if (illegal_enc) begin
      dec.alu_op   = 3'b000;
      dec.chosen   = 1'b0;
      dec.src1_sel = 2'b00;
      dec.src2_imm = 1'b1;
      dec.imm      = 32'd0;
      dec.rs1      = 5'd0;
      dec.rs2      = 5'd0;
      dec.rd       = 5'd0;
    end
`endif
  end

  logic   main_valid, skid_valid, main_valid_next, skid_valid_next;
  logic   ld_main_in, ld_main_skid, ld_skid;
  logic   in_ready_q;
  logic   xfer;
  entry_t main_q, skid_q;

  assign xfer = in_valid && in_ready_q;

  // Skid buffer control. The main entry refills from the skid entry first,
  // which keeps the order FIFO. The skid entry fills only behind a stalled
  // main entry.
  always_comb begin
    main_valid_next = main_valid;
    skid_valid_next = skid_valid;
    ld_main_in      = 1'b0;
    ld_main_skid    = 1'b0;
    ld_skid         = 1'b0;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        ld_main_skid    = 1'b1;
        main_valid_next = 1'b1;
        skid_valid_next = 1'b0;
      end else if (xfer) begin
        ld_main_in      = 1'b1;
        main_valid_next = 1'b1;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (xfer) begin
      ld_skid         = 1'b1;
      skid_valid_next = 1'b1;
    end
  end

  // Entry storage, valid bits and the registered in_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_valid <= main_valid_next;
      skid_valid <= skid_valid_next;
      in_ready_q <= !skid_valid_next;
      if (ld_main_skid)    main_q <= skid_q;
      else if (ld_main_in) main_q <= dec;
      if (ld_skid)         skid_q <= dec;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = main_valid;
  assign out_alu_op        = main_q.alu_op;
  assign out_alu_op_chosen = main_q.chosen;
  assign out_src1_sel      = main_q.src1_sel;
  assign out_src2_imm      = main_q.src2_imm;
  assign out_imm           = main_q.imm;
  assign out_rs1           = main_q.rs1;
  assign out_rs2           = main_q.rs2;
  assign out_rd            = main_q.rd;
  assign out_rd_we         = main_q.rd_we;
  assign out_illegal       = main_q.illegal;
  assign out_pc            = main_q.pc;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// tb_alu_ctrl_decode: scoreboard bench for alu_ctrl_decode. The expected
// decode for each table instruction is written out by hand from the
// instruction encoding. Optional feature macro: DEC_ILLEGAL_TRAP_EN.
module tb_alu_ctrl_decode;

  localparam int NT = 16;
  localparam int W  = 88;
  localparam logic [W-1:0] FULL_MASK = {W{1'b1}};
  localparam logic [W-1:0] TRAP_MASK = {54'b0, 2'b11, 32'hFFFF_FFFF};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_alu_op;
  logic        out_alu_op_chosen;
  logic [1:0]  out_src1_sel;
  logic        out_src2_imm;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rd_we, out_illegal;
  logic [31:0] out_pc;

  alu_ctrl_decode dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_alu_op_chosen(out_alu_op_chosen),
    .out_src1_sel(out_src1_sel), .out_src2_imm(out_src2_imm), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal), .out_pc(out_pc)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] tbl_inst [NT];
  logic [55:0] tbl_exp  [NT];
  logic        tbl_bad  [NT];

  logic [W-1:0] exp_q  [$];
  logic [W-1:0] mask_q [$];
  logic [W-1:0] cur_exp, cur_mask;

  function automatic logic [55:0] mk(input logic [2:0] op, input logic ch,
                                     input logic [1:0] sel, input logic s2,
                                     input logic [31:0] imm, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [4:0] rd,
                                     input logic we, input logic ill);
    return {op, ch, sel, s2, imm, rs1, rs2, rd, we, ill};
  endfunction

  task automatic set_entry(input int i, input logic [31:0] inst, input logic [55:0] e);
    tbl_inst[i] = inst;
    tbl_exp[i]  = e;
    tbl_bad[i]  = 1'b0;
  endtask

  task automatic set_bad(input int i, input logic [31:0] inst);
    tbl_inst[i] = inst;
    tbl_bad[i]  = 1'b1;
`ifdef DEC_ILLEGAL_TRAP_EN
    tbl_exp[i]  = mk(3'd0, 1'b0, 2'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
`else
    tbl_exp[i]  = mk(3'd0, 1'b0, 2'd0, 1'b1, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
`endif
  endtask

  task automatic init_table();
    set_entry(0,  32'h002081B3, mk(3'd0, 1'b0, 2'd0, 1'b0, 32'h0,        5'd1, 5'd2, 5'd3,  1'b1, 1'b0)); // add x3,x1,x2
    set_entry(1,  32'h407302B3, mk(3'd0, 1'b1, 2'd0, 1'b0, 32'h0,        5'd6, 5'd7, 5'd5,  1'b1, 1'b0)); // sub x5,x6,x7
    set_entry(2,  32'h40315093, mk(3'd5, 1'b1, 2'd0, 1'b1, 32'h3,        5'd2, 5'd0, 5'd1,  1'b1, 1'b0)); // srai x1,x2,3
    set_entry(3,  32'hFFF00093, mk(3'd0, 1'b0, 2'd0, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1,  1'b1, 1'b0)); // addi x1,x0,-1
    set_entry(4,  32'h12345537, mk(3'd0, 1'b0, 2'd1, 1'b1, 32'h12345000, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0)); // lui x10
    set_entry(5,  32'h00001117, mk(3'd0, 1'b0, 2'd2, 1'b1, 32'h00001000, 5'd0, 5'd0, 5'd2,  1'b1, 1'b0)); // auipc x2,1
    set_bad  (6,  32'h0000007F);                                                                              // bad opcode
    set_bad  (7,  32'h402140B3);                                                                              // xor with funct7=0100000
    set_entry(8,  32'h00411093, mk(3'd1, 1'b0, 2'd0, 1'b1, 32'h4,        5'd2, 5'd0, 5'd1,  1'b1, 1'b0)); // slli x1,x2,4
    set_entry(9,  32'h01F25193, mk(3'd5, 1'b0, 2'd0, 1'b1, 32'd31,       5'd4, 5'd0, 5'd3,  1'b1, 1'b0)); // srli x3,x4,31
    set_entry(10, 32'h0020B033, mk(3'd3, 1'b0, 2'd0, 1'b0, 32'h0,        5'd1, 5'd2, 5'd0,  1'b0, 1'b0)); // sltu x0,x1,x2
    set_entry(11, 32'h8002F293, mk(3'd7, 1'b0, 2'd0, 1'b1, 32'hFFFFF800, 5'd5, 5'd0, 5'd5,  1'b1, 1'b0)); // andi x5,x5,-2048
    set_bad  (12, 32'h40411093);                                                                              // slli with funct7=0100000
    set_entry(13, 32'h403150B3, mk(3'd5, 1'b1, 2'd0, 1'b0, 32'h0,        5'd2, 5'd3, 5'd1,  1'b1, 1'b0)); // sra x1,x2,x3
    set_entry(14, 32'h40000093, mk(3'd0, 1'b0, 2'd0, 1'b1, 32'h400,      5'd0, 5'd0, 5'd1,  1'b1, 1'b0)); // addi x1,x0,0x400
    set_bad  (15, 32'h60315093);                                                                              // srai with funct7=0110000
  endtask

  // Driver: present one instruction together with its expected decode
  task automatic drive(input int idx, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = tbl_inst[idx];
    in_pc    = pc;
    cur_exp  = {tbl_exp[idx], pc};
`ifdef DEC_ILLEGAL_TRAP_EN
    cur_mask = tbl_bad[idx] ? TRAP_MASK : FULL_MASK;
`else
    cur_mask = FULL_MASK;
`endif
  endtask

  // Driver: offer one instruction and return just after it has transferred
  task automatic send(input int idx, input logic [31:0] pc);
    bit ok = 0;
    drive(idx, pc);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_mis++;
      $display("FAIL send_timeout: in_ready stayed 0 for inst %h, needed 1", tbl_inst[idx]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    out_ready = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_mis++;
      $display("FAIL %s: %0d entries still expected, needed 0", name, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer,
  // and check that a stalled output entry holds its value
  logic [W-1:0] obs, prev_obs, exp_v, mask_v;
  bit           prev_stall = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      obs = {out_alu_op, out_alu_op_chosen, out_src1_sel, out_src2_imm, out_imm,
             out_rs1, out_rs2, out_rd, out_rd_we, out_illegal, out_pc};
      if (prev_stall) begin
        n_cmp++;
        if ({out_valid, obs} !== {1'b1, prev_obs}) begin
          n_mis++;
          $display("FAIL stall_hold: got %b/%h, needed 1/%h", out_valid, obs, prev_obs);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_mis++;
          $display("FAIL sb_unexpected: got %h, expected queue empty", obs);
        end else begin
          exp_v  = exp_q.pop_front();
          mask_v = mask_q.pop_front();
          if ((obs & mask_v) !== (exp_v & mask_v)) begin
            n_mis++;
            $display("FAIL sb_entry: got %h, needed %h (mask %h)", obs, exp_v, mask_v);
          end
        end
      end
      if (flush) begin
        exp_q.delete();
        mask_q.delete();
      end else if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        mask_q.push_back(cur_mask);
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_obs   = obs;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_mis++;
      $display("FAIL reset_hs: valid/ready got %b%b, needed 01", out_valid, in_ready);
    end
    n_cmp++;
    if ({out_alu_op, out_alu_op_chosen, out_src1_sel, out_src2_imm, out_imm, out_rs1,
         out_rs2, out_rd, out_rd_we, out_illegal, out_pc} !== {W{1'b0}}) begin
      n_mis++;
      $display("FAIL reset_fields: outputs nonzero, needed all 0");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    send(0, 32'h0000_1000);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_rs1, out_rs2, out_rd, out_rd_we, out_src2_imm} !==
        {1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0}) begin
      n_mis++;
      $display("FAIL latency_add: got v=%b rs1=%0d rs2=%0d rd=%0d we=%b s2=%b, needed 1/1/2/3/1/0",
               out_valid, out_rs1, out_rs2, out_rd, out_rd_we, out_src2_imm);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_decode();
    int c0;
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < NT; i++) send(i, 32'h0000_2000 + 32'(i * 4));
    n_cmp++;
    if (cyc - c0 !== NT) begin
      n_mis++;
      $display("FAIL throughput: %0d cycles for %0d instructions, needed %0d", cyc - c0, NT, NT);
    end
    wait_drain("decode_drain");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1, 32'h0000_3000);
    @(negedge clk);
    @(posedge clk); #1;
    drive(2, 32'h0000_3004);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL b2b_second: in_ready got %b, needed 1", in_ready);
    end
    @(posedge clk); #1;
    drive(3, 32'h0000_3008);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid, out_pc} !== {1'b0, 1'b1, 32'h0000_3000}) begin
        n_mis++;
        $display("FAIL b2b_full: ready/valid/pc got %b/%b/%h, needed 0/1/00003000",
                 in_ready, out_valid, out_pc);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL b2b_reopen: in_ready got %b, needed 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain("b2b_drain");
  endtask

  task automatic test_flush();
    // Buffer full: flush with an input offered but not accepted
    out_ready = 1'b0;
    send(4, 32'h0000_4000);
    send(5, 32'h0000_4004);
    drive(6, 32'h0000_4008);
    flush = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_mis++;
      $display("FAIL flush_full: valid/ready got %b%b, needed 01", out_valid, in_ready);
    end
    @(posedge clk); #1;
    // Main only: the input transferred in the flush cycle must vanish
    send(8, 32'h0000_4010);
    drive(9, 32'h0000_4014);
    flush = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_mis++;
      $display("FAIL flush_main: valid/ready got %b%b, needed 01", out_valid, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(11, 32'h0000_4018);
    wait_drain("flush_drain");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(13, 32'h0000_5000);
    send(14, 32'h0000_5004);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, out_pc} !== {1'b0, 1'b1, 32'h0}) begin
      n_mis++;
      $display("FAIL async_reset: valid/ready/pc got %b/%b/%h, needed 0/1/00000000",
               out_valid, in_ready, out_pc);
    end
    exp_q.delete();
    mask_q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(int'($urandom_range(0, NT - 1)), 32'h0001_0000 + 32'(i * 4));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    wait_drain("random_drain");
  endtask

  initial begin
    init_table();
    test_reset();
    test_latency();
    test_decode();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
